// File: rtl/rr_res_arbiter.sv
// Round-robin arbiter that sequences one shared multi-cycle resource between NumPorts requesters.
// Optional watchdog abort is built when RR_RES_ARBITER_WATCHDOG_EN is defined.
module rr_res_arbiter #(
    parameter int  NumPorts      = 4,
    parameter type T             = logic [7:0],
    parameter type O             = logic [7:0],
    parameter int  TimeoutCycles = 16,
    localparam int IdxW          = NumPorts > 1 ? $clog2(NumPorts) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumPorts-1:0] req_valid,
    output logic [NumPorts-1:0] req_ready,
    input  T                    req_data [NumPorts],
    output logic [NumPorts-1:0] rsp_valid,
    output O                    rsp_data,
    output logic                rsp_err,
    output logic                res_valid,
    input  logic                res_ready,
    output T                    res_data,
    input  logic                res_done,
    input  O                    res_result,
    output logic [IdxW-1:0]     grant,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [IdxW-1:0]     ptr;
    logic [IdxW-1:0]     win;
    logic [IdxW-1:0]     ptr_nxt;
    logic                found;
    logic                done_ok;
    logic                tmo;
    logic [NumPorts-1:0] grant_oh;

    // first valid port at or after ptr, wrapping modulo NumPorts
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && req_valid[(int'(ptr) + i) % NumPorts]) begin
                found = 1'b1;
                win   = IdxW'((int'(ptr) + i) % NumPorts);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && found)
            req_ready[win] = 1'b1;
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NumPorts; i++)
            grant_oh[i] = (grant == IdxW'(i));
    end

    assign ptr_nxt = (grant == IdxW'(NumPorts - 1)) ? '0 : grant + 1'b1;
    assign done_ok = res_done && ((state == WAIT) || (state == ISSUE && res_ready));
    assign busy    = (state != IDLE);

`ifdef RR_RES_ARBITER_WATCHDOG_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt;

    assign tmo = busy && (cnt == CntW'(TimeoutCycles - 1));

    // held at zero in IDLE, so it starts from zero on every ISSUE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_err <= 1'b0;
        else if (done_ok)
            rsp_err <= 1'b0;
        else if (tmo)
            rsp_err <= 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TimeoutCycles > 0);
    assign tmo        = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == IDLE) begin
                if (found) begin
                    res_data  <= req_data[win];
                    grant     <= win;
                    res_valid <= 1'b1;
                    state     <= ISSUE;
                end
            end else if (done_ok) begin
                rsp_valid <= grant_oh;
                rsp_data  <= res_result;
                res_valid <= 1'b0;
                ptr       <= ptr_nxt;
                state     <= IDLE;
            end else if (tmo) begin
                rsp_valid <= grant_oh;
                rsp_data  <= '0;
                res_valid <= 1'b0;
                ptr       <= ptr_nxt;
                state     <= IDLE;
            end else if (state == ISSUE && res_ready) begin
                res_valid <= 1'b0;
                state     <= WAIT;
            end
        end
    end
endmodule

// File: tb/tb_rr_res_arbiter.sv
// Randomized + directed bench for rr_res_arbiter; transaction-level model feeds a response scoreboard.
module tb_rr_res_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [7:0]   req_data [N];
    logic [N-1:0] rsp_valid;
    logic [7:0]   rsp_data;
    logic         rsp_err;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   res_data;
    logic         res_done = 1'b0;
    logic [7:0]   res_result = '0;
    logic [1:0]   grant;
    logic         busy;

    rr_res_arbiter #(.NumPorts(N), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_done(res_done), .res_result(res_result),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] oh;
        logic [7:0]   data;
        logic         err;
        int           due;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // transaction-level model: owner, pointer, and whether the issue was taken
    bit         m_busy, m_issued;
    int         m_ptr, m_grant, m_cnt;
    logic [7:0] m_data;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_ptr = 0; m_grant = 0; m_cnt = 0; m_data = '0;
        exp_q.delete();
    endtask

    task automatic finish_txn(input logic [7:0] d, input logic e);
        rsp_t r;
        logic [N-1:0] one;
        one    = 1;
        r.oh   = one << m_grant;
        r.data = d;
        r.err  = e;
        r.due  = cyc + 1;
        exp_q.push_back(r);
        m_busy = 0;
        m_ptr  = (m_grant + 1) % N;
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic rr, input logic rd, input logic [7:0] rslt);
        int w;
        @(negedge clk);
        req_valid = v; res_ready = rr; res_done = rd; res_result = rslt;
        for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
        #1;
        w = -1;
        if (!m_busy)
            for (int i = 0; i < N; i++)
                if (w < 0 && v[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("res_valid", 32'(res_valid), 32'(m_busy && !m_issued));
        if (m_busy && !m_issued) chk("res_data", 32'(res_data), 32'(m_data));
        chk("grant", 32'(grant), 32'(m_grant));
        if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1; m_issued = 0; m_grant = w; m_data = req_data[w]; m_cnt = 0;
            end
        end else if ((m_issued || rr) && rd) begin
            finish_txn(rslt, 1'b0);
        end else begin
            if (rr) m_issued = 1;
            m_cnt++;
`ifdef RR_RES_ARBITER_WATCHDOG_EN
            if (m_cnt >= TO) finish_txn(8'h00, 1'b1);
`endif
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
    endtask

    // scoreboard monitor: a response must appear exactly on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.oh));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end else if (rsp_valid !== '0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected 0 (cycle %0d)", rsp_valid, cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) req_data[i] = '0;
        model_reset();
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;

        // priority from ptr, then pointer advance
        cycle(4'b1001, 0, 0, 8'h00);
        cycle(4'b1001, 1, 0, 8'h00);
        cycle(4'b0000, 0, 1, 8'h3C);
        cycle(4'b1001, 0, 0, 8'h00);
        cycle(4'b0000, 1, 1, 8'h5A);

        // all ports busy, done two cycles after issue
        repeat (5) begin
            cycle(4'b1111, 0, 0, 8'h00);
            cycle(4'b1111, 1, 0, 8'h00);
            cycle(4'b1111, 0, 0, 8'h00);
            cycle(4'b1111, 0, 1, 8'($urandom));
        end
        cycle(4'b0000, 0, 0, 8'h00);

        // resource stalls issue for three cycles
        cycle(4'b1111, 0, 0, 8'h00);
        repeat (3) cycle(4'b1111, 0, 1, 8'h00);
        cycle(4'b0000, 1, 0, 8'h00);
        cycle(4'b0000, 0, 1, 8'h96);

        // accept and complete in the same cycle
        cycle(4'b0100, 0, 0, 8'h00);
        cycle(4'b0000, 1, 1, 8'hA5);
        cycle(4'b0000, 0, 0, 8'h00);

        // asynchronous reset while waiting, then a stale done
        cycle(4'b0010, 0, 0, 8'h00);
        cycle(4'b0000, 1, 0, 8'h00);
        cycle(4'b0000, 0, 0, 8'h00);
        @(negedge clk);
        req_valid = '0; res_ready = 0; res_done = 0;
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0000, 0, 1, 8'h77);
        cycle(4'b0000, 1, 1, 8'h77);

        // resource never completes
        cycle(4'b0001, 0, 0, 8'h00);
        cycle(4'b0000, 1, 0, 8'h00);
        repeat (20) cycle(4'b0000, 0, 0, 8'h00);
        cycle(4'b0000, 0, 1, 8'h11);

        repeat (400)
            cycle(N'($urandom), 1'($urandom), ($urandom % 4) == 0, 8'($urandom));

        repeat (3) cycle(4'b0000, 1, 1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
